// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: a PC plus a 2-entry {pc, instruction} buffer in front of decode,
// with redirect flush and an IDLE/RUN/HOLD control FSM.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      fifo [2];
  logic        head;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic [31:0] pc;
  state_t      state;
  logic        pop;
  logic        push;
  logic        tail;

  assign imem_address   = pc;
  assign if_valid       = (count != 2'd0) & ~redirect_valid;
  assign if_pc          = (count != 2'd0) ? fifo[head].pc    : 32'h0;
  assign if_instruction = (count != 2'd0) ? fifo[head].instr : 32'h0;

  assign pop  = if_valid & if_ready;
  assign push = (state != IDLE) & enable & ~redirect_valid & ((count != 2'd2) | pop);
  // With two slots the tail is head+count mod 2; when full, push only happens alongside
  // a pop, so overwriting the departing head slot is exactly the new tail.
  assign tail = head ^ count[0];

  always_comb begin
    count_next = count;
    if (push & ~pop)      count_next = count + 2'd1;
    else if (pop & ~push) count_next = count - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      head  <= 1'b0;
      state <= IDLE;
    end else if (redirect_valid) begin
      pc    <= {redirect_target[31:2], 2'b00};
      count <= 2'd0;
      head  <= 1'b0;
      state <= enable ? RUN : IDLE;
    end else begin
      count <= count_next;
      if (pop)  head <= ~head;
      if (push) pc   <= pc + 32'd4;
      if (!enable) state <= IDLE;
      else begin
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= (count_next == 2'd2) ? HOLD : RUN;
          HOLD:    state <= (pop & ~push) ? RUN : HOLD;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= '{pc: pc, instr: imem_instruction};
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, rdy, rv;
  logic [31:0] rt;
  logic [31:0] imem_addr, imem_ins, ifi, ifp;
  logic        ifv;
  logic        en2, rdy2, rv2;
  logic [31:0] rt2, addr2, ins2, i2, p2;
  logic        v2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_ins = rom(imem_addr);
  assign ins2     = rom(addr2);

  fetch_sequencer dut (
    .clk(clk), .reset(rst), .enable(en), .imem_address(imem_addr),
    .imem_instruction(imem_ins), .redirect_valid(rv), .redirect_target(rt),
    .if_valid(ifv), .if_ready(rdy), .if_instruction(ifi), .if_pc(ifp)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(rst), .enable(en2), .imem_address(addr2),
    .imem_instruction(ins2), .redirect_valid(rv2), .redirect_target(rt2),
    .if_valid(v2), .if_ready(rdy2), .if_instruction(i2), .if_pc(p2)
  );

  // Reference model: a queue of fetched entries, the next fetch address, and a run flag.
  ent_t        mq[$];
  logic [31:0] mpc;
  bit          mrun;
  logic        ob_v, ex_v;
  logic [31:0] ob_i, ob_p, ob_a, ex_i, ex_p, ex_a;

  task automatic model_reset();
    mq.delete();
    mpc  = 32'h0;
    mrun = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rdy = 1'b0; rv = 1'b0; rt = 32'h0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one cycle, capture DUT and model views at the negedge, advance the model at the posedge.
  task automatic cycle(input logic e, input logic r, input logic v, input logic [31:0] t);
    bit   pop, push;
    ent_t ne;
    en = e; rdy = r; rv = v; rt = t;
    @(negedge clk);
    ob_v = ifv; ob_i = ifi; ob_p = ifp; ob_a = imem_addr;
    ex_v = (mq.size() != 0) && !v;
    ex_i = (mq.size() != 0) ? mq[0].ins : 32'h0;
    ex_p = (mq.size() != 0) ? mq[0].pc  : 32'h0;
    ex_a = mpc;
    @(posedge clk);
    pop  = ex_v && r;
    push = mrun && e && !v && (mq.size() < 2 || pop);
    if (v) begin
      mq.delete();
      mpc = {t[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        ne.pc = mpc; ne.ins = rom(mpc);
        mq.push_back(ne);
        mpc = mpc + 32'd4;
      end
    end
    mrun = e;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; rdy = 1'b0; rv = 1'b0; rt = 32'h0;
    en2 = 1'b0; rdy2 = 1'b1; rv2 = 1'b0; rt2 = 32'h0;
    model_reset();
    #3;
    checks++;
    if ({ifv, ifp, ifi, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b pc=%h ins=%h addr=%h want 0/0/0/0", ifv, ifp, ifi, imem_addr);
    end
    checks++;
    if (addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL reset_pc_param: got %h want fffffffc", addr2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({ob_v, ob_p, ob_i, ob_a} !== {ex_v, ex_p, ex_i, ex_a}) begin
        errors++;
        $display("FAIL stream_model c%0d: got v=%b pc=%h ins=%h addr=%h want v=%b pc=%h ins=%h addr=%h",
                 c, ob_v, ob_p, ob_i, ob_a, ex_v, ex_p, ex_i, ex_a);
      end
      if (c >= 2) begin
        checks++;
        if ({ob_v, ob_p} !== {1'b1, 32'((c - 2) * 4)}) begin
          errors++; $display("FAIL stream_seq c%0d: got v=%b pc=%h want 1/%h", c, ob_v, ob_p, (c - 2) * 4);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({ob_v, ob_p, ob_i, ob_a} !== {ex_v, ex_p, ex_i, ex_a}) begin
        errors++;
        $display("FAIL stall_model c%0d: got v=%b pc=%h addr=%h want v=%b pc=%h addr=%h",
                 c, ob_v, ob_p, ob_a, ex_v, ex_p, ex_a);
      end
      if (c >= 3) begin
        checks++;
        if ({ob_v, ob_p, ob_a} !== {1'b1, 32'h0, 32'h8}) begin
          errors++; $display("FAIL stall_hold c%0d: got v=%b pc=%h addr=%h want 1/0/8", c, ob_v, ob_p, ob_a);
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({ob_v, ob_p, ob_i} !== {1'b1, 32'(c * 4), rom(32'(c * 4))}) begin
        errors++; $display("FAIL stall_drain c%0d: got v=%b pc=%h ins=%h want 1/%h", c, ob_v, ob_p, ob_i, c * 4);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0016);
    checks++;
    if ({ob_v, ob_p} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL redirect_cycle: got v=%b head=%h want 0/0", ob_v, ob_p);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({ob_v, ob_a} !== {1'b0, 32'h14}) begin
      errors++; $display("FAIL redirect_pc: got v=%b addr=%h want 0/14", ob_v, ob_a);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({ob_v, ob_p, ob_i} !== {1'b1, 32'h14, rom(32'h14)}) begin
      errors++; $display("FAIL redirect_fetch: got v=%b pc=%h ins=%h want 1/14", ob_v, ob_p, ob_i);
    end
    // Redirect while parked in IDLE still moves the PC.
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (ob_a !== 32'h100) begin
      errors++; $display("FAIL redirect_idle: got addr=%h want 100", ob_a);
    end
  endtask

  task automatic test_random();
    logic e, r, v;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      e = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 1);
      v = ($urandom_range(0, 9) == 0);
      cycle(e, r, v, $urandom);
      checks++;
      if ({ob_v, ob_p, ob_i, ob_a} !== {ex_v, ex_p, ex_i, ex_a}) begin
        errors++;
        $display("FAIL random_model c%0d: got v=%b pc=%h ins=%h addr=%h want v=%b pc=%h ins=%h addr=%h",
                 c, ob_v, ob_p, ob_i, ob_a, ex_v, ex_p, ex_i, ex_a);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (ifv !== 1'b1) begin
      errors++; $display("FAIL async_prefill: got v=%b want 1", ifv);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ifv, ifp, imem_addr} !== {1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL async_reset: got v=%b pc=%h addr=%h want 0/0/0", ifv, ifp, imem_addr);
    end
    model_reset();
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({ob_v, ob_p, ob_i, ob_a} !== {ex_v, ex_p, ex_i, ex_a}) begin
        errors++;
        $display("FAIL async_model c%0d: got v=%b pc=%h addr=%h want v=%b pc=%h addr=%h",
                 c, ob_v, ob_p, ob_a, ex_v, ex_p, ex_a);
      end
      if (c == 2) begin
        checks++;
        if ({ob_v, ob_p} !== {1'b1, 32'h0}) begin
          errors++; $display("FAIL async_first: got v=%b pc=%h want 1/0", ob_v, ob_p);
        end
      end
    end
  endtask

  task automatic test_wrap();
    en2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({v2, p2, i2} !== {1'b1, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC)}) begin
      errors++; $display("FAIL wrap_first: got v=%b pc=%h ins=%h want 1/fffffffc", v2, p2, i2);
    end
    @(posedge clk); #1;
    checks++;
    if ({v2, p2, i2} !== {1'b1, 32'h0, rom(32'h0)}) begin
      errors++; $display("FAIL wrap_second: got v=%b pc=%h ins=%h want 1/00000000", v2, p2, i2);
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
